// File: rtl/rvvi_retire_buffer.sv
// Dual-retire to single-slot RVVI stream buffer.
// Up to two retire events per cycle are queued in program order and presented
// one per cycle with a running order number. A valid slot that cannot be
// accepted is dropped and the sticky overflow flag is raised.
module rvvi_retire_buffer #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 in_valid,
    input  logic [2*XLEN-1:0]          in_pc,
    input  logic [2*ILEN-1:0]          in_insn,
    input  logic [1:0]                 in_trap,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_insn,
    output logic                       out_trap,
    output logic [63:0]                out_order,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Highest occupancy that still leaves room for a full dual retire.
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] insn_mem [DEPTH];
    logic            trap_mem [DEPTH];

    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   occ;
    logic [63:0]     order_cnt;
    logic            ovf;

    logic [1:0]      n_enq;
    logic            deq;

    // Readiness comes from the registered count only, so a dequeue in the
    // same cycle never opens the gate early.
    assign in_ready  = (occ <= READY_MAX);
    assign out_valid = (occ != '0);
    assign deq       = out_valid && out_ready;
    assign n_enq     = in_ready ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;

    assign count     = occ;
    assign overflow  = ovf;
    assign out_order = order_cnt;
    assign out_pc    = out_valid ? pc_mem[rptr]   : '0;
    assign out_insn  = out_valid ? insn_mem[rptr] : '0;
    assign out_trap  = out_valid ? trap_mem[rptr] : 1'b0;

    // Entry storage: slot 0 is older, so it always lands first at wptr.
    always_ff @(posedge clk) begin
        if (in_ready) begin
            if (in_valid == 2'b11) begin
                pc_mem[wptr]             <= in_pc[XLEN-1:0];
                insn_mem[wptr]           <= in_insn[ILEN-1:0];
                trap_mem[wptr]           <= in_trap[0];
                pc_mem[wptr + AW'(1)]    <= in_pc[2*XLEN-1:XLEN];
                insn_mem[wptr + AW'(1)]  <= in_insn[2*ILEN-1:ILEN];
                trap_mem[wptr + AW'(1)]  <= in_trap[1];
            end else if (in_valid[0]) begin
                pc_mem[wptr]   <= in_pc[XLEN-1:0];
                insn_mem[wptr] <= in_insn[ILEN-1:0];
                trap_mem[wptr] <= in_trap[0];
            end else if (in_valid[1]) begin
                pc_mem[wptr]   <= in_pc[2*XLEN-1:XLEN];
                insn_mem[wptr] <= in_insn[2*ILEN-1:ILEN];
                trap_mem[wptr] <= in_trap[1];
            end
        end
    end

    // Pointer, occupancy, order and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
            order_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            wptr <= wptr + AW'(n_enq);
            occ  <= occ + CW'(n_enq) - CW'(deq);
            if (deq) begin
                rptr      <= rptr + AW'(1);
                order_cnt <= order_cnt + 64'd1;
            end
            if (!in_ready && (in_valid != 2'b00)) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
